mult_div_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit beside the ALU in the execute stage.
- Takes the two register-file read operands (rs, rt) and an op code from control.
- Produces 64-bit results into HI/LO registers, read by the writeback mux (mfhi/mflo path).
- Iterative radix-2 datapath: one bit per clock, busy/done handshake toward control for stalling.

---
 rtl/mult_div_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative radix-2 multiply/divide unit that sits beside the ALU in the
//   execute stage. It retires one bit per clock. Results land in HI/LO for the
//   mfhi/mflo writeback path.
//
//   Ports:
//     clk         : system clock, rising edge
//     rst         : synchronous, active-high reset
//     start       : operation request, sampled only while idle
//     op          : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     in1         : rs operand (multiplicand / dividend)
//     in2         : rt operand (multiplier / divisor)
//     busy        : operation in progress, so control stalls
//     done        : one-cycle pulse when HI/LO have just been written
//     hi          : product upper half, or remainder
//     lo          : product lower half, or quotient
//     div_by_zero : divide was accepted with in2 == 0
//
//   Build option:
//     MDU_EARLY_OUT_EN : multiplies finish as soon as the remaining multiplier
//                        bits are all zero. Results are identical either way.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned AW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;     // negate product / quotient
  logic                 rneg_q, rneg_d;   // negate remainder
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        mcand_q, mcand_d; // shifted multiplicand
  logic [W-1:0]         mplier_q, mplier_d; // multiplier shift reg / divisor
  logic [AW-1:0]        acc_q, acc_d;     // product, or {remainder, quotient}
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic [W-1:0]         hi_q, hi_d;
  logic [W-1:0]         lo_q, lo_d;

  // Operand magnitudes and sign bookkeeping at accept
  logic         is_signed;
  logic         in1_neg, in2_neg;
  logic [W-1:0] mag1, mag2;

  assign is_signed = ~op[0];
  assign in1_neg   = is_signed & in1[W-1];
  assign in2_neg   = is_signed & in2[W-1];
  assign mag1      = in1_neg ? -in1 : in1;
  assign mag2      = in2_neg ? -in2 : in2;

  // Restoring divide step: the partial remainder shifted left, with the next
  // dividend bit brought in, is held one bit wider so that divisors with
  // the top bit set still compare correctly.
  logic [W:0] rem_sh, diff;
  assign rem_sh = acc_q[AW-1:W-1];
  assign diff   = rem_sh - {1'b0, mplier_q};

  // Final sign correction
  logic [AW-1:0] prod_fix;
  logic [W-1:0]  quo, rem, quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo      = acc_q[W-1:0];
  assign rem      = acc_q[AW-1:W];
  assign quo_fix  = neg_q  ? -quo : quo;
  assign rem_fix  = rneg_q ? -rem : rem;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_d    = in1_neg ^ in2_neg;
          rneg_d   = in1_neg;
          cnt_d    = CNT_WIDTH'(W);
          mplier_d = mag2;
          busy_d   = 1'b1;
          dbz_d    = 1'b0;
          if (op[1]) begin
            mcand_d = '0;
            acc_d   = {{W{1'b0}}, mag1};
            state_d = S_RUN;
            if (in2 == '0) begin
              // Park the raw dividend in the upper half so that FIN can
              // return it unchanged in HI.
              dbz_d   = 1'b1;
              acc_d   = {in1, {W{1'b0}}};
              state_d = S_FIN;
            end
          end else begin
            mcand_d = {{W{1'b0}}, mag1};
            acc_d   = '0;
            state_d = S_RUN;
`ifdef MDU_EARLY_OUT_EN
            if (mag2 == '0) state_d = S_FIN;
`endif
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (is_div_q) begin
          if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
          else          acc_d = {acc_q[AW-2:0], 1'b0};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = {mcand_q[AW-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[W-1:1]};
        end
        if (cnt_d == '0) state_d = S_FIN;
`ifdef MDU_EARLY_OUT_EN
        if (!is_div_q && mplier_d == '0) state_d = S_FIN;
`endif
      end

      S_FIN: begin
        if (dbz_q) begin
          hi_d = acc_q[AW-1:W];
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[AW-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed-vector bench for mult_div_unit. Expected results are worked out
//   by hand. Expected latency follows the build option MDU_EARLY_OUT_EN.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1, in2;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

  mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Edges from the accept edge to the edge that raises done
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] m;
    int msb;
    if (o[1]) return (b == 0) ? 1 : 33;
    m = (!o[0] && b[31]) ? -b : b;
    if (m == 0) return 1;
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    return msb + 2;
`else
    if (o[1] && b == 0) return 1;
    return 33;
`endif
  endfunction

  // Issues one operation immediately (may land in a done cycle), scrambles
  // the operand inputs during RUN, then waits for done with a cycle bound.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    int busy_drop;
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in1 = ~a; in2 = ~b;
    check({tag, "/busy_acc"}, {63'd0, busy}, 64'd1);
    check({tag, "/dbz_acc"}, {63'd0, div_by_zero}, {63'd0, (o[1] && b == 0)});
    n = 0;
    busy_drop = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && busy !== 1'b1) busy_drop++;
    end
    check({tag, "/latency"}, 64'(n), 64'(exp_lat(o, b)));
    check({tag, "/busy_run"}, 64'(busy_drop), 64'd0);
    check({tag, "/busy_done"}, {63'd0, busy}, 64'd0);
    check({tag, "/hilo"}, {hi, lo}, {ehi, elo});
    check({tag, "/dbz_done"}, {63'd0, div_by_zero}, {63'd0, (o[1] && b == 0)});
  endtask

  initial begin
    int dones;
    logic [63:0] res;
    rst = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {27'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    // Issued in the done cycle of the previous divide
    run_op("divu_b2b",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_zero", 2'b11, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);

    repeat (5) @(posedge clk);
    #1;
    check("hold", {hi, lo}, {32'd0, 32'h80000000});
    check("hold_done", {63'd0, done}, 64'd0);

    run_op("multu_5x3", 2'b01, 32'd5,        32'd3,        32'd0,        32'd15);
    run_op("multu_x0",  2'b01, 32'd9,        32'd0,        32'd0,        32'd0);
    run_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0);
    run_op("divu_big",  2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1);
    run_op("div_negd",  2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

    // Reset in the middle of an operation
    op = 2'b01; in1 = 32'd5; in2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", {27'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh op with an extra start pulsed while busy
    op = 2'b01; in1 = 32'd6; in2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    in1 = 32'd100; in2 = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    res = '1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        res = {hi, lo};
      end
    end
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_res", res, 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
